conv_event_fifo: RTL
====================

CONV_EVENT_FIFO -- requirements
Module: conv_event_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of one stored entry in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning the depth is DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-2, meaning the count at or above which almost_full asserts.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning the asynchronous active-high reset.
REQ-007 SHALL have port write_data, input, DATA_WIDTH bits, meaning the entry to enqueue.
REQ-008 SHALL have port write_en, input, 1 bit, meaning the producer's push request.
REQ-009 SHALL have port read_en, input, 1 bit, meaning the consumer's pop request.
REQ-010 SHALL have port read_data, output, DATA_WIDTH bits, meaning the oldest entry (first-word-fall-through).
REQ-011 SHALL have port empty, output, 1 bit, meaning no entries are held.
REQ-012 SHALL have port full, output, 1 bit, meaning DEPTH entries are held.
REQ-013 SHALL have port almost_full, output, 1 bit, meaning count >= AFULL_LEVEL.
REQ-014 SHALL have port count, output, ADDR_WIDTH+1 bits, meaning the current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow, output, 1 bit, meaning a sticky flag for a rejected push.
REQ-016 SHALL have port underflow, output, 1 bit, meaning a sticky flag for a rejected pop.
REQ-017 SHALL have port flag_clr, input, 1 bit, meaning a synchronous clear of overflow and underflow.

Function
REQ-018 SHALL store entries in an array of DEPTH words, addressed by write and read pointers ADDR_WIDTH+1 bits wide, with the MSB as the wrap bit.
REQ-019 SHALL derive empty as (wr_ptr == rd_ptr) and full as (low bits equal and wrap bits differ), registered-state based with no combinational path from write_en or read_en.
REQ-020 SHALL drive count = wr_ptr - rd_ptr modulo 2**(ADDR_WIDTH+1).
REQ-021 SHALL accept a push when write_en=1 and full=0: store write_data at wr_ptr and increment wr_ptr on that edge.
REQ-022 SHALL accept a pop when read_en=1 and empty=0: increment rd_ptr on that edge.
REQ-023 SHALL drive read_data combinationally from mem[rd_ptr] whenever empty=0, and drive it to 0 when empty=1.
REQ-024 SHALL have latency such that data pushed at edge N is visible on read_data, with empty=0, in the cycle after edge N; there is no same-cycle bypass.
REQ-025 SHALL, when full=1 and write_en=1 and read_en=1, perform both operations, leave count at DEPTH, and not set overflow.
REQ-026 SHALL, when full=1 and write_en=1 and read_en=0, drop the push, leave the pointers unchanged, and set overflow.
REQ-027 SHALL, when empty=1 and read_en=1, ignore the pop and set underflow; a simultaneous push is still accepted, so count becomes 1.
REQ-028 SHALL, when 0 < count < DEPTH and write_en and read_en are both asserted, perform both, leaving count unchanged.
REQ-029 SHALL wrap pointers naturally from 2**(ADDR_WIDTH+1)-1 to 0 with no special handling.
REQ-030 SHALL clear overflow and underflow at the edge where flag_clr=1; a new violation in that same cycle takes priority and the flag is set.
REQ-031 SHALL register nothing in the data path other than the memory and pointers, so a complete push-to-pop occupies one slot for at least one cycle.

Reset
REQ-032 SHALL, while rst=1, immediately force: pointers=0, empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0, read_data=0.
REQ-033 SHALL ignore write_en, read_en and flag_clr while rst=1; memory contents are not reset and are not observable after reset.
REQ-034 SHALL, on rst asserting mid-operation (for example, with count=5), discard all entries, with outputs reaching reset values without waiting for a clk edge.

Verification
REQ-035 SHALL cover this scenario: after reset, push 0x11, 0x22, 0x33 on consecutive cycles -> empty=0 one cycle after the first push, read_data=0x11, count=3; pop three times -> read_data 0x22, then 0x33, then 0 with empty=1.
REQ-036 SHALL cover this scenario: push 16 entries (defaults) -> full=1, count=16, almost_full=1 from count=14; a 17th push alone -> dropped, overflow=1, count=16.
REQ-037 SHALL cover this scenario: full, then push 0xAA and pop simultaneously -> count=16, overflow=0, and 0xAA is read out last after 15 further pops.
REQ-038 SHALL cover this scenario: empty, then pop alone -> underflow=1, count=0; then pop and push 0x5C together -> count=1, read_data=0x5C; flag_clr -> underflow=0.
REQ-039 SHALL cover this scenario: 40 pushes and 40 pops interleaved across pointer wrap -> output order matches input order and count never exceeds 16.
REQ-040 SHALL cover this scenario: rst asserted between clock edges with count=5 -> empty=1, count=0, read_data=0 before the next edge, and a push after release is read back correctly.

Source files
------------

// File: rtl/conv_event_fifo_if.sv
// Handshake bundle for conv_event_fifo.
//   master : producer/consumer side; drives write_data, write_en, read_en, flag_clr and
//            observes read_data, empty, full, almost_full, count, overflow, underflow.
//   slave  : the FIFO itself; the mirror image of master.
// DATA_WIDTH and ADDR_WIDTH must match the parameters of the FIFO instance bound to it.
interface conv_event_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) ();

  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_en;
  logic                  read_en;
  logic                  flag_clr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_data,
    output write_en,
    output read_en,
    output flag_clr,
    input  read_data,
    input  empty,
    input  full,
    input  almost_full,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  write_data,
    input  write_en,
    input  read_en,
    input  flag_clr,
    output read_data,
    output empty,
    output full,
    output almost_full,
    output count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/conv_event_fifo.sv
// Synchronous first-word-fall-through FIFO with sticky overflow/underflow flags.
//
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset; pointers and flags clear immediately
//   bus  - conv_event_fifo_if.slave
//            write_data/write_en : push request
//            read_en             : pop request
//            flag_clr            : synchronous clear of overflow/underflow
//            read_data           : oldest entry, 0 while empty
//            empty/full/almost_full/count : occupancy status, from registered state only
//            overflow/underflow  : sticky error flags
//
// Pointers are ADDR_WIDTH+1 bits; the extra MSB is a wrap bit that separates full from empty.
module conv_event_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned AFULL_LEVEL = (2 ** ADDR_WIDTH) - 2
) (
  input  logic              clk,
  input  logic              rst,
  conv_event_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PtrW  = ADDR_WIDTH + 1;

  localparam logic [PtrW-1:0] AfullCnt = PtrW'(AFULL_LEVEL);

  // Storage and pointer state
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  // Status derived from registered pointers only
  logic            empty_w;
  logic            full_w;
  logic [PtrW-1:0] count_w;

  // Accepted operations this cycle
  logic push;
  logic pop;
  logic overflow_set;
  logic underflow_set;

  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  // Modular subtraction gives the right occupancy across pointer wrap.
  assign count_w = wr_ptr_q - rd_ptr_q;

  always_comb begin
    pop  = bus.read_en && !empty_w;
    // When full, a push is still legal if a pop frees the slot on the same edge.
    push = bus.write_en && (!full_w || bus.read_en);

    overflow_set  = bus.write_en && full_w && !bus.read_en;
    underflow_set = bus.read_en && empty_w;
  end

  // Next-state for pointers and sticky flags
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Clear first so a violation in the same cycle wins.
    if (bus.flag_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (overflow_set) begin
      overflow_d = 1'b1;
    end
    if (underflow_set) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Memory is not reset; stale contents are hidden because reset makes the FIFO empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.write_data;
    end
  end

  // Outputs
  always_comb begin
    bus.read_data = '0;
    if (!empty_w) begin
      bus.read_data = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.almost_full = (count_w >= AfullCnt);
  assign bus.count       = count_w;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

  // Structural invariants
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count_w <= PtrW'(DEPTH));
  a_not_full_and_empty : assert property (@(posedge clk) disable iff (rst)
    !(full_w && empty_w));

endmodule
